// File: rtl/envelope_follower_if.sv
// envelope_follower_if: shared filter-count constant and the sample/envelope bus
// between the band filters, the envelope follower and the mixer.
package constants;
  localparam int N_FILTERS = 4;
endpackage

interface envelope_follower_if #(parameter int N_CH = constants::N_FILTERS);
  logic valid_in;
  logic [4:0] attack_shift;
  logic [4:0] release_shift;
  logic signed [31:0] band_channels [N_CH];
  logic signed [31:0] envelope_channels [N_CH];
  logic valid_out;
  logic busy;
  logic dropped;
  modport master (
    output valid_in, attack_shift, release_shift, band_channels,
    input envelope_channels, valid_out, busy, dropped
  );
  modport slave (
    input valid_in, attack_shift, release_shift, band_channels,
    output envelope_channels, valid_out, busy, dropped
  );
endinterface

// File: rtl/envelope_follower.sv
// envelope_follower: per-channel attack/release envelope detector; one channel is
// rectified and filtered every two cycles, results published together on commit.
module envelope_follower #(parameter int N_CH = constants::N_FILTERS) (
  input logic clk_in,
  input logic rst_in,
  envelope_follower_if.slave bus
);
  localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;
  typedef enum logic [1:0] {IDLE, RECTIFY, FILTER, COMMIT} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [4:0] atk_q, atk_d, rel_q, rel_d;
  logic signed [31:0] band_q [N_CH];
  logic signed [31:0] band_d [N_CH];
  logic signed [31:0] work_q [N_CH];
  logic signed [31:0] work_d [N_CH];
  logic signed [31:0] env_q [N_CH];
  logic signed [31:0] env_d [N_CH];
  logic signed [31:0] rect_q, rect_d, cur, rect;
  logic signed [32:0] diff, step;
  logic valid_out_q, valid_out_d, busy_q, busy_d, dropped_q, dropped_d;
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    atk_d = atk_q;
    rel_d = rel_q;
    band_d = band_q;
    work_d = work_q;
    env_d = env_q;
    rect_d = rect_q;
    valid_out_d = state_q == COMMIT;
    busy_d = state_q != IDLE;
    dropped_d = dropped_q | (bus.valid_in & (state_q != IDLE));
    cur = band_q[idx_q];
    rect = (cur == 32'sh8000_0000) ? 32'sh7fff_ffff : ((cur < 0) ? -cur : cur);
    // rect and work are both non-negative, so a 33-bit difference never overflows
    diff = 33'(rect_q) - 33'(work_q[idx_q]);
    step = (diff > 0) ? (diff >>> atk_q) : (diff >>> rel_q);
    case (state_q)
      IDLE: if (bus.valid_in) begin
        band_d = bus.band_channels;
        atk_d = bus.attack_shift;
        rel_d = bus.release_shift;
        idx_d = '0;
        state_d = RECTIFY;
      end
      RECTIFY: begin
        rect_d = rect;
        state_d = FILTER;
      end
      FILTER: begin
        work_d[idx_q] = 32'(33'(work_q[idx_q]) + step);
        idx_d = idx_q + 1'b1;
        state_d = (idx_q == IW'(N_CH - 1)) ? COMMIT : RECTIFY;
      end
      default: begin
        env_d = work_q;
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
      idx_q <= '0;
      atk_q <= '0;
      rel_q <= '0;
      band_q <= '{default: '0};
      work_q <= '{default: '0};
      env_q <= '{default: '0};
      rect_q <= '0;
      valid_out_q <= 1'b0;
      busy_q <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      atk_q <= atk_d;
      rel_q <= rel_d;
      band_q <= band_d;
      work_q <= work_d;
      env_q <= env_d;
      rect_q <= rect_d;
      valid_out_q <= valid_out_d;
      busy_q <= busy_d;
      dropped_q <= dropped_d;
    end
  end
  assign bus.envelope_channels = env_q;
  assign bus.valid_out = valid_out_q;
  assign bus.busy = busy_q;
  assign bus.dropped = dropped_q;
endmodule
